// File: rtl/lpc_frame_dma_ctrl_pkg.sv
// Shared types and constants for the LPC frame DMA sequencer.
package lpc_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    STREAM,
    DRAIN,
    DONE,
    ERR
  } state_t;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int BYTES_PER_SAMPLE = 2;
  // Sample count to byte count is a left shift by log2(BYTES_PER_SAMPLE).
  localparam int LEN_SHIFT        = $clog2(BYTES_PER_SAMPLE);

endpackage

// File: rtl/lpc_frame_dma_ctrl_if.sv
// Streaming handshake between the DMA sequencer and the LPC algorithm core.
interface lpc_frame_dma_ctrl_if
  import lpc_dma_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic              alg_in_valid;
  logic [DATA_W-1:0] alg_in_data;
  logic              alg_in_ready;
  logic              alg_out_valid;
  logic [DATA_W-1:0] alg_out_data;
  logic              alg_out_ready;

  modport master (
    output alg_in_valid, alg_in_data, alg_out_ready,
    input  alg_in_ready, alg_out_valid, alg_out_data
  );

  modport slave (
    input  alg_in_valid, alg_in_data, alg_out_ready,
    output alg_in_ready, alg_out_valid, alg_out_data
  );
endinterface

// File: rtl/lpc_frame_dma_ctrl_fifo.sv
// Synchronous FIFO built on a flop array; the head word is always presented on dout.
module lpc_sync_fifo
  import lpc_dma_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/lpc_frame_dma_ctrl.sv
// Frame sequencer: launches the DDR3 read/write masters and streams one frame
// read-master -> algorithm -> output FIFO -> write-master.
module lpc_frame_dma_ctrl
  import lpc_dma_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int OFIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_src_base,
  input  logic [ADDR_W-1:0] cmd_dst_base,
  input  logic [ADDR_W-1:0] cmd_num_samples,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic              cmd_error,
  output logic              algorithm_run,
  output logic              rm_fixed_location,
  output logic              wm_fixed_location,
  output logic [ADDR_W-1:0] rm_read_base,
  output logic [ADDR_W-1:0] wm_write_base,
  output logic [ADDR_W-1:0] rm_read_length,
  output logic [ADDR_W-1:0] wm_write_length,
  output logic              rm_go,
  output logic              wm_go,
  input  logic              rm_done,
  input  logic              wm_done,
  input  logic              rm_data_available,
  input  logic [DATA_W-1:0] rm_buffer_output_data,
  output logic              rm_read_buffer,
  input  logic              wm_buffer_full,
  output logic              wm_write_buffer,
  output logic [DATA_W-1:0] wm_buffer_input_data,
  lpc_frame_dma_ctrl_if.master alg
);
  state_t            state;
  logic [ADDR_W-1:0] num_samples;
  logic [ADDR_W-1:0] in_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              rm_done_seen;
  logic              wm_done_seen;
  logic              in_stream;
  logic              start_ok;
  logic              bad_cmd;
  logic              ofifo_full;
  logic              ofifo_empty;
  logic              ofifo_push;

  assign rm_fixed_location = 1'b0;
  assign wm_fixed_location = 1'b0;
  assign in_stream         = (state == STREAM);
  assign start_ok          = (state == IDLE) && cmd_start;
  assign bad_cmd           = (cmd_num_samples == '0) || cmd_num_samples[ADDR_W-1] ||
                             cmd_src_base[0] || cmd_dst_base[0];

  // Datapath handshakes are combinational but gated so nothing moves outside STREAM.
  assign alg.alg_in_valid  = in_stream && rm_data_available && (in_cnt < num_samples);
  assign alg.alg_in_data   = in_stream ? rm_buffer_output_data : '0;
  assign rm_read_buffer    = alg.alg_in_valid && alg.alg_in_ready;
  assign alg.alg_out_ready = in_stream && !ofifo_full;
  assign ofifo_push        = alg.alg_out_valid && alg.alg_out_ready;
  assign wm_write_buffer   = in_stream && !ofifo_empty && !wm_buffer_full;

  lpc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OFIFO_DEPTH)
  ) u_ofifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .clr   (start_ok),
    .push  (ofifo_push),
    .din   (alg.alg_out_data),
    .pop   (wm_write_buffer),
    .dout  (wm_buffer_input_data),
    .full  (ofifo_full),
    .empty (ofifo_empty)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state           <= IDLE;
      num_samples     <= '0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      rm_done_seen    <= 1'b0;
      wm_done_seen    <= 1'b0;
      cmd_busy        <= 1'b0;
      cmd_done        <= 1'b0;
      cmd_error       <= 1'b0;
      algorithm_run   <= 1'b0;
      rm_go           <= 1'b0;
      wm_go           <= 1'b0;
      rm_read_base    <= '0;
      wm_write_base   <= '0;
      rm_read_length  <= '0;
      wm_write_length <= '0;
    end else begin
      rm_go     <= 1'b0;
      wm_go     <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
      if (rm_read_buffer)  in_cnt  <= in_cnt + 1'b1;
      if (wm_write_buffer) out_cnt <= out_cnt + 1'b1;
      // Master completions may arrive before the last write; keep them sticky.
      if (state inside {STREAM, DRAIN}) begin
        if (rm_done) rm_done_seen <= 1'b1;
        if (wm_done) wm_done_seen <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cmd_start) begin
            num_samples     <= cmd_num_samples;
            rm_read_base    <= cmd_src_base;
            wm_write_base   <= cmd_dst_base;
            rm_read_length  <= cmd_num_samples << LEN_SHIFT;
            wm_write_length <= cmd_num_samples << LEN_SHIFT;
            in_cnt          <= '0;
            out_cnt         <= '0;
            rm_done_seen    <= 1'b0;
            wm_done_seen    <= 1'b0;
            cmd_busy        <= 1'b1;
            if (bad_cmd) begin
              state     <= ERR;
              cmd_error <= 1'b1;
            end else begin
              state <= LAUNCH;
              rm_go <= 1'b1;
              wm_go <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state         <= STREAM;
          algorithm_run <= 1'b1;
        end
        STREAM: begin
          if ((out_cnt == num_samples) ||
              (wm_write_buffer && ((out_cnt + 1'b1) == num_samples))) begin
            state         <= DRAIN;
            algorithm_run <= 1'b0;
          end
        end
        DRAIN: begin
          if ((rm_done_seen || rm_done) && (wm_done_seen || wm_done)) begin
            state    <= DONE;
            cmd_done <= 1'b1;
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          cmd_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lpc_frame_dma_ctrl.sv
// Directed bench for lpc_frame_dma_ctrl: command table plus multi-cycle corner sequences.
module tb_lpc_frame_dma_ctrl;
  import lpc_dma_pkg::*;

  typedef struct {
    logic [31:0] n;
    logic [31:0] src;
    logic [31:0] dst;
    bit          exp_err;
    logic [31:0] exp_len;
  } vec_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        cmd_start;
  logic [31:0] cmd_src_base, cmd_dst_base, cmd_num_samples;
  logic        cmd_busy, cmd_done, cmd_error, algorithm_run;
  logic        rm_fixed_location, wm_fixed_location;
  logic [31:0] rm_read_base, wm_write_base, rm_read_length, wm_write_length;
  logic        rm_go, wm_go, rm_done, wm_done;
  logic        rm_data_available;
  logic [15:0] rm_buffer_output_data;
  logic        rm_read_buffer;
  logic        wm_buffer_full, wm_write_buffer;
  logic [15:0] wm_buffer_input_data;
  logic        alg_rdy_en;
  logic        frame_init;

  logic [15:0] src_words [65];
  logic [15:0] wr_words  [64];
  int          rd_total;
  int          rd_idx, wr_cnt, rm_go_cnt, wm_go_cnt, done_cnt, err_cnt;
  int          occ, occ_max, full_wr;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk_clk = ~clk_clk;

  lpc_frame_dma_ctrl_if #(.DATA_W(16)) alg_bus ();

  // Pass-through algorithm core, optionally stalled by alg_rdy_en.
  assign alg_bus.alg_in_ready  = alg_bus.alg_out_ready && alg_rdy_en;
  assign alg_bus.alg_out_valid = alg_bus.alg_in_valid && alg_rdy_en;
  assign alg_bus.alg_out_data  = alg_bus.alg_in_data;

  lpc_frame_dma_ctrl #(.DATA_W(16), .ADDR_W(32), .OFIFO_DEPTH(16)) dut (
    .clk_clk               (clk_clk),
    .reset_reset_n         (reset_reset_n),
    .cmd_start             (cmd_start),
    .cmd_src_base          (cmd_src_base),
    .cmd_dst_base          (cmd_dst_base),
    .cmd_num_samples       (cmd_num_samples),
    .cmd_busy              (cmd_busy),
    .cmd_done              (cmd_done),
    .cmd_error             (cmd_error),
    .algorithm_run         (algorithm_run),
    .rm_fixed_location     (rm_fixed_location),
    .wm_fixed_location     (wm_fixed_location),
    .rm_read_base          (rm_read_base),
    .wm_write_base         (wm_write_base),
    .rm_read_length        (rm_read_length),
    .wm_write_length       (wm_write_length),
    .rm_go                 (rm_go),
    .wm_go                 (wm_go),
    .rm_done               (rm_done),
    .wm_done               (wm_done),
    .rm_data_available     (rm_data_available),
    .rm_buffer_output_data (rm_buffer_output_data),
    .rm_read_buffer        (rm_read_buffer),
    .wm_buffer_full        (wm_buffer_full),
    .wm_write_buffer       (wm_write_buffer),
    .wm_buffer_input_data  (wm_buffer_input_data),
    .alg                   (alg_bus)
  );

  // Read-master model: show-ahead buffer holding the frame's source words.
  always_comb begin
    rm_data_available     = (rd_idx < rd_total);
    rm_buffer_output_data = (rd_idx < 64) ? src_words[rd_idx] : 16'h0;
  end

  // Write-master capture and pulse/occupancy bookkeeping.
  always @(posedge clk_clk) begin
    if (!reset_reset_n || frame_init) begin
      rd_idx <= 0; wr_cnt <= 0; rm_go_cnt <= 0; wm_go_cnt <= 0;
      done_cnt <= 0; err_cnt <= 0; occ <= 0; occ_max <= 0; full_wr <= 0;
    end else begin
      if (rm_read_buffer) rd_idx <= rd_idx + 1;
      if (wm_write_buffer) begin
        if (wr_cnt < 64) wr_words[wr_cnt] <= wm_buffer_input_data;
        wr_cnt <= wr_cnt + 1;
        if (wm_buffer_full) full_wr <= full_wr + 1;
      end
      if (rm_go)     rm_go_cnt <= rm_go_cnt + 1;
      if (wm_go)     wm_go_cnt <= wm_go_cnt + 1;
      if (cmd_done)  done_cnt  <= done_cnt + 1;
      if (cmd_error) err_cnt   <= err_cnt + 1;
      occ <= occ + ((alg_bus.alg_out_valid && alg_bus.alg_out_ready) ? 1 : 0)
                 - (wm_write_buffer ? 1 : 0);
      if (occ > occ_max) occ_max <= occ;
    end
  end

  function automatic logic any_out();
    return cmd_busy | cmd_done | cmd_error | algorithm_run | rm_fixed_location |
           wm_fixed_location | (|rm_read_base) | (|wm_write_base) | (|rm_read_length) |
           (|wm_write_length) | rm_go | wm_go | rm_read_buffer | wm_write_buffer |
           (|wm_buffer_input_data) | alg_bus.alg_in_valid | (|alg_bus.alg_in_data) |
           alg_bus.alg_out_ready;
  endfunction

  function automatic int order_errs(input int n);
    int e = 0;
    for (int i = 0; i < n && i < 64; i++)
      if (wr_words[i] !== src_words[i]) e++;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Clears the monitors, loads source words and issues a one-cycle start.
  // Returns at the negedge inside cycle k+1.
  task automatic apply_stimulus(input logic [31:0] n, input logic [31:0] src, input logic [31:0] dst);
    @(negedge clk_clk);
    frame_init = 1'b1;
    for (int i = 0; i < 65; i++) src_words[i] = 16'(src[15:0] ^ 16'(i * 37 + 5));
    rd_total = (n > 64) ? 0 : int'(n);
    @(negedge clk_clk);
    frame_init      = 1'b0;
    cmd_start       = 1'b1;
    cmd_num_samples = n;
    cmd_src_base    = src;
    cmd_dst_base    = dst;
    @(negedge clk_clk);
    cmd_start = 1'b0;
  endtask

  // Plays the master done pulses and optional backpressure until cmd_done.
  // done_lat is cycles from wm_done to cmd_done (-1 on timeout).
  task automatic run_frame(input int n, input int wm_delay, input bit stress,
                           output int done_lat, output bit rm_in_stream);
    int  cyc = 0;
    int  wm_wait = -1;
    int  wm_cyc = -1;
    bit  rm_sent = 0;
    bit  wm_sent = 0;
    done_lat = -1;
    rm_in_stream = 0;
    while (cyc < 3000) begin
      @(negedge clk_clk);
      if (cmd_done) begin
        done_lat = (wm_cyc < 0) ? -1 : cyc - wm_cyc;
        break;
      end
      rm_done = 1'b0;
      wm_done = 1'b0;
      if (stress) begin
        wm_buffer_full = ((cyc / 3) % 2) == 1;
        alg_rdy_en     = ($urandom_range(3) != 0);
      end
      if (!rm_sent && rd_idx == n) begin
        rm_done      = 1'b1;
        rm_sent      = 1;
        rm_in_stream = algorithm_run;
      end
      if (!wm_sent && wr_cnt == n) begin
        if (wm_wait < 0) wm_wait = wm_delay;
        if (wm_wait == 0) begin
          wm_done = 1'b1;
          wm_sent = 1;
          wm_cyc  = cyc;
        end else wm_wait--;
      end
      cyc++;
    end
    rm_done = 1'b0; wm_done = 1'b0; wm_buffer_full = 1'b0; alg_rdy_en = 1'b1;
    check_output("frame_completes", (done_lat >= 0) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk_clk);
  endtask

  vec_t vecs [7];
  int   lat;
  bit   rm_st;
  int   t;

  initial begin
    vecs[0] = '{32'd8,          32'h1000, 32'h2000, 1'b0, 32'd16};
    vecs[1] = '{32'd0,          32'h1000, 32'h2000, 1'b1, 32'd0};
    vecs[2] = '{32'd4,          32'h1001, 32'h2000, 1'b1, 32'd0};
    vecs[3] = '{32'd4,          32'h1000, 32'h2003, 1'b1, 32'd0};
    vecs[4] = '{32'h8000_0000,  32'h1000, 32'h2000, 1'b1, 32'd0};
    vecs[5] = '{32'd3,          32'h0040, 32'h0080, 1'b0, 32'd6};
    vecs[6] = '{32'd1,          32'h0010, 32'h0020, 1'b0, 32'd2};

    reset_reset_n = 1'b0; cmd_start = 1'b0; cmd_src_base = '0; cmd_dst_base = '0;
    cmd_num_samples = '0; rm_done = 1'b0; wm_done = 1'b0; wm_buffer_full = 1'b0;
    alg_rdy_en = 1'b1; frame_init = 1'b0; rd_total = 0;
    for (int i = 0; i < 65; i++) src_words[i] = 16'h0;

    repeat (3) @(negedge clk_clk);
    check_output("reset_outputs_zero", 32'(any_out()), 32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check_output("idle_outputs_zero", 32'(any_out()), 32'd0);

    for (int v = 0; v < 7; v++) begin
      $display("[TB] vector %0d: N=%0d src=0x%0h dst=0x%0h", v, vecs[v].n, vecs[v].src, vecs[v].dst);
      apply_stimulus(vecs[v].n, vecs[v].src, vecs[v].dst);
      check_output("busy_k1", 32'(cmd_busy), 32'd1);
      check_output("error_k1", 32'(cmd_error), 32'(vecs[v].exp_err));
      check_output("rm_go_k1", 32'(rm_go), 32'(!vecs[v].exp_err));
      check_output("wm_go_k1", 32'(wm_go), 32'(!vecs[v].exp_err));
      if (vecs[v].exp_err) begin
        @(negedge clk_clk);
        check_output("err_busy_clear", 32'(cmd_busy), 32'd0);
        repeat (3) @(negedge clk_clk);
        check_output("err_pulse_count", 32'(err_cnt), 32'd1);
        check_output("err_no_go", 32'(rm_go_cnt + wm_go_cnt), 32'd0);
      end else begin
        check_output("rm_read_length", rm_read_length, vecs[v].exp_len);
        check_output("wm_write_length", wm_write_length, vecs[v].exp_len);
        check_output("rm_read_base", rm_read_base, vecs[v].src);
        check_output("wm_write_base", wm_write_base, vecs[v].dst);
        run_frame(int'(vecs[v].n), 0, 1'b0, lat, rm_st);
        check_output("busy_after_done", 32'(cmd_busy), 32'd0);
        repeat (3) @(negedge clk_clk);
        check_output("words_written", 32'(wr_cnt), vecs[v].n);
        check_output("word_order_errs", 32'(order_errs(int'(vecs[v].n))), 32'd0);
        check_output("done_pulse_count", 32'(done_cnt), 32'd1);
        check_output("rm_go_cycles", 32'(rm_go_cnt), 32'd1);
        check_output("wm_go_cycles", 32'(wm_go_cnt), 32'd1);
      end
    end

    // Backpressure on both sides of the stream.
    $display("[TB] stress N=32");
    apply_stimulus(32'd32, 32'h3000, 32'h4000);
    run_frame(32, 0, 1'b1, lat, rm_st);
    repeat (2) @(negedge clk_clk);
    check_output("stress_reads", 32'(rd_idx), 32'd32);
    check_output("stress_writes", 32'(wr_cnt), 32'd32);
    check_output("stress_order_errs", 32'(order_errs(32)), 32'd0);
    check_output("stress_fifo_max_ok", 32'(occ_max <= 16), 32'd1);
    check_output("stress_write_while_full", 32'(full_wr), 32'd0);
    check_output("stress_done_count", 32'(done_cnt), 32'd1);

    // Early rm_done, late wm_done.
    $display("[TB] early rm_done / late wm_done");
    apply_stimulus(32'd8, 32'h0100, 32'h0200);
    run_frame(8, 10, 1'b0, lat, rm_st);
    check_output("rm_done_in_stream", 32'(rm_st), 32'd1);
    check_output("done_after_wm_done", 32'(lat), 32'd1);

    // A start request mid-stream must be ignored.
    $display("[TB] start during STREAM");
    apply_stimulus(32'd16, 32'h5000, 32'h6000);
    t = 0;
    while (!algorithm_run && t < 100) begin @(negedge clk_clk); t++; end
    check_output("reach_stream", 32'(algorithm_run), 32'd1);
    cmd_start = 1'b1; cmd_src_base = 32'h7000; cmd_dst_base = 32'h7800; cmd_num_samples = 32'd2;
    @(negedge clk_clk);
    cmd_start = 1'b0;
    @(negedge clk_clk);
    check_output("ignored_rm_base", rm_read_base, 32'h5000);
    check_output("ignored_wm_base", wm_write_base, 32'h6000);
    check_output("ignored_length", rm_read_length, 32'd32);
    run_frame(16, 0, 1'b0, lat, rm_st);
    repeat (2) @(negedge clk_clk);
    check_output("ignored_words", 32'(wr_cnt), 32'd16);
    check_output("ignored_go_count", 32'(rm_go_cnt), 32'd1);

    // Reset in the middle of a frame, then a fresh short frame.
    $display("[TB] reset mid-frame");
    apply_stimulus(32'd16, 32'h0A00, 32'h0B00);
    t = 0;
    while (rd_idx < 5 && t < 100) begin @(negedge clk_clk); t++; end
    check_output("reach_sample5", 32'(rd_idx), 32'd5);
    reset_reset_n = 1'b0;
    #1;
    check_output("midframe_reset_zero", 32'(any_out()), 32'd0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    apply_stimulus(32'd4, 32'h0C00, 32'h0D00);
    check_output("post_reset_go", 32'(rm_go), 32'd1);
    run_frame(4, 0, 1'b0, lat, rm_st);
    repeat (2) @(negedge clk_clk);
    check_output("post_reset_words", 32'(wr_cnt), 32'd4);
    check_output("post_reset_order", 32'(order_errs(4)), 32'd0);
    check_output("post_reset_done", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
